// File: rtl/colcomp_mult_pipe.sv
// Three-stage pipelined column-compression multiplier with valid/ready flow control.
// Define COLCOMP_MULT_SIGNED_EN for two's complement operands (Baugh-Wooley correction).
module colcomp_mult_pipe #(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned CW   = $clog2(WIDTH + 1) + 1;
  localparam int unsigned NCOL = 2 * WIDTH - 1;
  localparam int unsigned PW   = 2 * WIDTH;

  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] pp_q [WIDTH];
  logic [WIDTH-1:0] pp_d [WIDTH];
  logic [CW-1:0]    cnt_q [NCOL];
  logic [CW-1:0]    cnt_d [NCOL];
  logic [PW-1:0]    sum_d;
  logic             stall;

  assign stall     = v3_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3_q;
  assign busy      = v1_q | v2_q | v3_q;

  // pp_d[i][j] carries weight 2^(i+j)
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp_d[i][j] = in_a[j] & in_b[i];
`ifdef COLCOMP_MULT_SIGNED_EN
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
          pp_d[i][j] = ~pp_d[i][j];
        end
`endif
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NCOL; k++) begin
      cnt_d[k] = '0;
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        cnt_d[i+j] = cnt_d[i+j] + CW'(pp_q[i][j]);
      end
    end
`ifdef COLCOMP_MULT_SIGNED_EN
    cnt_d[WIDTH] = cnt_d[WIDTH] + CW'(1);
`endif
  end

  // Carry-propagate resolution; bits above 2*WIDTH are discarded
  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      sum_d = sum_d + (PW'(cnt_q[k]) << k);
    end
`ifdef COLCOMP_MULT_SIGNED_EN
    sum_d = sum_d + {1'b1, {(PW - 1){1'b0}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      out_p <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pp_q[i] <= '0;
      end
      for (int unsigned k = 0; k < NCOL; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (!stall) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          pp_q[i] <= pp_d[i];
        end
      end
      if (v1_q) begin
        for (int unsigned k = 0; k < NCOL; k++) begin
          cnt_q[k] <= cnt_d[k];
        end
      end
      if (v2_q) begin
        out_p <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_colcomp_mult_pipe.sv
// Randomized scoreboard bench for colcomp_mult_pipe: WIDTH=6 directed/flow tests plus
// concurrent WIDTH=2/8/16 sweeps; follows COLCOMP_MULT_SIGNED_EN for signedness.
module tb_colcomp_mult_pipe;

  logic        clk;
  logic        rst;
  logic        rst_s;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_a;
  logic [5:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_p;
  logic        busy;

  int total = 0;
  int bad   = 0;
  longint sb[$];
  logic prev_stall = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  colcomp_mult_pipe #(.WIDTH(6)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  // Reference product of two w-bit operands, truncated to 2w bits.
  function automatic longint model(input longint a, input longint b, input int w);
    longint sa, sb_v, m;
    m    = (longint'(1) << (2 * w)) - 1;
    sa   = a;
    sb_v = b;
`ifdef COLCOMP_MULT_SIGNED_EN
    if (((a >> (w - 1)) & 1) != 0) sa = a - (longint'(1) << w);
    if (((b >> (w - 1)) & 1) != 0) sb_v = b - (longint'(1) << w);
`endif
    return (sa * sb_v) & m;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main DUT compare process
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("busy", longint'(busy), longint'(sb.size() != 0));
      check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (prev_stall) check("hold_valid", longint'(out_valid), 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("prod", longint'(out_p), sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) sb.push_back(model(longint'(in_a), longint'(in_b), 6));
    end
  end

  // Width sweep instances
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 16);
    logic           iv, ir, ov, ordy, bz, done;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    longint q[$];
    int acc = 0;

    colcomp_mult_pipe #(.WIDTH(W)) u_sw (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .out_valid (ov),
      .out_ready (ordy),
      .out_p     (p),
      .busy      (bz)
    );

    always @(negedge clk) begin
      if (rst_s) begin
        q.delete();
      end else begin
        if (ov) begin
          if (q.size() == 0) begin
            check($sformatf("sweep%0d_spurious", W), 1, 0);
          end else begin
            check($sformatf("sweep%0d_prod", W), longint'(p), q[0]);
            if (ordy) void'(q.pop_front());
          end
        end
        if (iv && ir) begin
          q.push_back(model(longint'(a), longint'(b), W));
          acc++;
        end
      end
    end

    initial begin
      int cyc;
      iv = 1'b0; a = '0; b = '0; ordy = 1'b1; done = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
        iv   = ($urandom_range(0, 3) != 0);
        a    = W'($urandom);
        b    = W'($urandom);
        ordy = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        cyc++;
      end
      check($sformatf("sweep%0d_count", W), longint'(acc >= 1000), 1);
      iv = 1'b0;
      ordy = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("sweep%0d_drain", W), longint'(q.size()), 0);
      done = 1'b1;
    end
  end

  // One operand pair from idle; checks 3-cycle latency and the literal product.
  task automatic directed(input logic [5:0] a, input logic [5:0] b, input longint want);
    int cnt;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt++;
    end while (!out_valid && cnt < 10);
    check("latency", longint'(cnt), 3);
    check("directed_prod", longint'(out_p), want);
  endtask

  initial begin
    int nvalid, first, last, not_ready, t;
    longint e0;
    rst = 1'b1; rst_s = 1'b1;
    in_valid = 1'b1; in_a = 6'd5; in_b = 6'd7; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_p", longint'(out_p), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0; rst_s = 1'b0; in_valid = 1'b0;

`ifdef COLCOMP_MULT_SIGNED_EN
    directed(6'h20, 6'h20, 64'h400);
    directed(6'h3F, 6'h01, 64'hFFF);
    directed(6'h1F, 6'h20, 64'hC20);
    directed(6'h3F, 6'h3F, 64'h001);
`else
    directed(6'd63, 6'd63, 64'hF81);
    directed(6'd0, 6'd45, 0);
    directed(6'd1, 6'd37, 37);
`endif

    // Streaming: 20 back-to-back pairs
    @(posedge clk);
    #1;
    nvalid = 0; first = -1; last = -1; not_ready = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 20);
      in_a = 6'($urandom);
      in_b = 6'($urandom);
      @(negedge clk);
      if (!in_ready) not_ready++;
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stream_count", longint'(nvalid), 20);
    check("stream_contig", longint'(last - first + 1), 20);
    check("stream_in_ready", longint'(not_ready), 0);

    // Backpressure with three items in flight
    e0 = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = 6'($urandom);
      in_b = 6'($urandom);
      if (k == 0) e0 = model(longint'(in_a), longint'(in_b), 6);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_p", longint'(out_p), e0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_drain", longint'(sb.size()), 0);

    // Reset with two items in flight; offered input during reset is dropped
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_a = 6'($urandom);
      in_b = 6'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_p", longint'(out_p), 0);
    check("midrst_busy", longint'(busy), 0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_idle_busy", longint'(busy), 0);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = 6'($urandom);
      in_b      = 6'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drain", longint'(sb.size()), 0);

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_done", longint'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
